issue_pair_scheduler: RTL and testbench
=======================================

// Module: issue_pair_scheduler
// PURPOSE
//   Issue-slot scheduler for the dual-issue ID stage. Each cycle it decides whether the
//   fetched instruction pair issues together, issues split over two cycles, or stalls.
//   Inputs are the IF/ID pair fields plus the external load-use hazard and the branch
//   flush. Outputs are the slot-valid signals and the fetch stall that holds PC and IF/ID.
// PARAMETERS
//   CNT_W   32   width of the performance counters (only with ISSUE_PERF_CNT_EN)
// PORTS
//   clk             in   1    clock, rising edge
//   rst             in   1    synchronous reset, active-low
//   valid_in        in   1    IF/ID holds a valid pair
//   rs1,rt1,dest1   in   5    inst1 source and destination registers
//   wr1,mem1,br1    in   1    inst1 writes a reg / accesses memory / is a branch or jump
//   rs2,rt2,dest2   in   5    inst2 fields, same meaning as inst1
//   wr2,mem2,br2    in   1    inst2 flags, same meaning as inst1
//   ld_hazard       in   1    load-use stall from the hazard detector
//   flush           in   1    branch/jump redirect; kills the ID pair
//   slot0_valid     out  1    slot 0 issues this cycle
//   slot0_sel       out  1    slot 0 source: 0 = inst1, 1 = inst2 (split second half)
//   slot1_valid     out  1    slot 1 issues inst2 this cycle
//   fetch_stall     out  1    hold PC and IF/ID
//   split_cnt       out  CNT_W  split issues (ISSUE_PERF_CNT_EN only)
//   stall_cnt       out  CNT_W  ld_hazard stall cycles (ISSUE_PERF_CNT_EN only)
// BEHAVIOUR
//   - State register: FULL (both pending) or HALF (inst1 issued, inst2 pending).
//   - Outputs are combinational from state and inputs. State updates on clk.
//   - rst==0: next state is FULL and counters clear. While rst==0, every output is 0.
//   - split = valid_in & ( wr1 & dest1!=0 & (rs2==dest1 | rt2==dest1)   // RAW
//             | wr1 & wr2 & dest1==dest2 & dest1!=0                     // WAW
//             | mem1 & mem2 | br2 )                                      // struct, br in slot0 only
//   - Priority (highest first): flush > ld_hazard > split logic.
//   - flush: all slot valids are 0, fetch_stall=0, next state FULL (the HALF remnant is dropped).
//   - valid_in==0: all outputs 0, state is held.
//   - FULL & ld_hazard: no issue, fetch_stall=1, stay FULL.
//   - FULL & split: slot0_valid=1, slot0_sel=0, slot1_valid=0, fetch_stall=1, next state HALF.
//   - FULL & !split: slot0_valid=1, slot0_sel=0, slot1_valid=1, fetch_stall=0.
//   - HALF & ld_hazard: no issue, fetch_stall=1, stay HALF.
//   - HALF otherwise: slot0_valid=1, slot0_sel=1, slot1_valid=0, fetch_stall=0,
//     next state FULL. inst2 issues exactly once.
//   - The scheduler never issues slot1 without slot0. Latency is 0 cycles from ID inputs.
// CONFIGURATION
//   ISSUE_PERF_CNT_EN defined: split_cnt increments on each FULL->HALF transition, and
//     stall_cnt increments on each cycle where valid_in & ld_hazard & !flush. Both counters
//     saturate at all-ones and clear on reset.
//   ISSUE_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.
// STRUCTURE
//   issue_pkg: state encoding (ST_FULL=1'b0, ST_HALF=1'b1) and SEL_INST1/SEL_INST2 constants.
//   Sub-module pair_dep_check (combinational) computes split from the pair fields.
//   The FSM and the optional counters live in this module.
// TESTING
//   1 independent pair (rs2=3, dest1=5, no mem/br): slot0=slot1=1, sel=0, stall=0 for 1 cycle.
//   2 RAW (dest1=5, wr1=1, rt2=5): cycle0 slot0=1/sel=0/stall=1, cycle1 slot0=1/sel=1/stall=0.
//   3 dest1=0, wr1=1, rs2=0: no split, both issue (writes to $0 ignored).
//   4 mem1=mem2=1 with ld_hazard high in HALF for 2 cycles: stall=1 and no issue for 2 cycles,
//     then sel=1 issue. stall_cnt=2, split_cnt=1 (with ISSUE_PERF_CNT_EN).
//   5 flush asserted in HALF: no issue, stall=0, next cycle FULL and new pair issues both.
//   6 rst low mid-HALF for 1 cycle: all outputs 0, then FULL and counters 0.

Source files
------------

// File: rtl/issue_pkg.sv
// issue_pkg: shared state encoding and slot-0 source select constants for the issue scheduler
package issue_pkg;
  typedef enum logic {ST_FULL = 1'b0, ST_HALF = 1'b1} state_t;
  localparam logic SEL_INST1 = 1'b0;
  localparam logic SEL_INST2 = 1'b1;
endpackage

// File: rtl/pair_dep_check.sv
// pair_dep_check: decides whether the fetched pair must be split across two cycles
module pair_dep_check (
  input  logic       valid_in,
  input  logic [4:0] dest1,
  input  logic       wr1,
  input  logic       mem1,
  input  logic [4:0] rs2,
  input  logic [4:0] rt2,
  input  logic [4:0] dest2,
  input  logic       wr2,
  input  logic       mem2,
  input  logic       br2,
  output logic       split
);
  logic live1;
  assign live1 = wr1 && dest1 != 5'd0;
  assign split = valid_in && ((live1 && (rs2 == dest1 || rt2 == dest1))
                           || (live1 && wr2 && dest1 == dest2)
                           || (mem1 && mem2)
                           || br2);
endmodule

// File: rtl/issue_pair_scheduler.sv
// issue_pair_scheduler: dual-issue ID slot scheduler; optional perf counters under ISSUE_PERF_CNT_EN
module issue_pair_scheduler
  import issue_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rt1,
  input  logic [4:0]       dest1,
  input  logic             wr1,
  input  logic             mem1,
  input  logic             br1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rt2,
  input  logic [4:0]       dest2,
  input  logic             wr2,
  input  logic             mem2,
  input  logic             br2,
  input  logic             ld_hazard,
  input  logic             flush,
  output logic             slot0_valid,
  output logic             slot0_sel,
  output logic             slot1_valid,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] split_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t st, nxt;
  logic split, go;
  logic unused_fields;
  assign unused_fields = ^{rs1, rt1, br1};
  pair_dep_check u_dep (
    .valid_in (valid_in),
    .dest1    (dest1),
    .wr1      (wr1),
    .mem1     (mem1),
    .rs2      (rs2),
    .rt2      (rt2),
    .dest2    (dest2),
    .wr2      (wr2),
    .mem2     (mem2),
    .br2      (br2),
    .split    (split)
  );
  assign go = rst && !flush && valid_in;
  // state register: FULL after reset
  always_ff @(posedge clk) begin
    if (!rst) st <= ST_FULL;
    else st <= nxt;
  end
  // next state: flush drops any HALF remnant; idle or load-use hazard holds
  always_comb begin
    nxt = st;
    if (flush) nxt = ST_FULL;
    else if (valid_in && !ld_hazard) nxt = (st == ST_FULL && split) ? ST_HALF : ST_FULL;
  end
  // slot outputs: zero-latency from state and ID inputs
  always_comb begin
    slot0_valid = go && !ld_hazard;
    slot0_sel   = (go && !ld_hazard && st == ST_HALF) ? SEL_INST2 : SEL_INST1;
    slot1_valid = go && !ld_hazard && st == ST_FULL && !split;
    fetch_stall = go && (ld_hazard || (st == ST_FULL && split));
  end
`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] split_q, stall_q;
  // saturating counters of split issues and load-use stall cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      split_q <= '0;
      stall_q <= '0;
    end else begin
      if (st == ST_FULL && nxt == ST_HALF && split_q != '1) split_q <= split_q + CNT_W'(1);
      if (valid_in && ld_hazard && !flush && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
    end
  end
  assign split_cnt = rst ? split_q : '0;
  assign stall_cnt = rst ? stall_q : '0;
`else
  assign split_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_issue_pair_scheduler.sv
// tb_issue_pair_scheduler: directed spec scenarios plus randomized run against a behavioural model
module tb_issue_pair_scheduler;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, valid_in, wr1, mem1, br1, wr2, mem2, br2, ld_hazard, flush;
  logic [4:0] rs1, rt1, dest1, rs2, rt2, dest2;
  logic slot0_valid, slot0_sel, slot1_valid, fetch_stall;
  logic [CW-1:0] split_cnt, stall_cnt;
  int total = 0;
  int bad = 0;
  bit m_half = 1'b0;
  int m_split = 0;
  int m_stall = 0;

  issue_pair_scheduler #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .rs1(rs1), .rt1(rt1), .dest1(dest1), .wr1(wr1), .mem1(mem1), .br1(br1),
    .rs2(rs2), .rt2(rt2), .dest2(dest2), .wr2(wr2), .mem2(mem2), .br2(br2),
    .ld_hazard(ld_hazard), .flush(flush),
    .slot0_valid(slot0_valid), .slot0_sel(slot0_sel), .slot1_valid(slot1_valid),
    .fetch_stall(fetch_stall), .split_cnt(split_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {slot0_valid, slot0_sel, slot1_valid, fetch_stall};
  endfunction

  task automatic expect_out(input string tag, input logic [3:0] e);
    #1;
    chk(tag, outs(), e);
  endtask

  task automatic set_pair(input logic v, input logic [4:0] r1, t1, d1, input logic w1, m1, b1,
                          input logic [4:0] r2, t2, d2, input logic w2, m2, b2);
    valid_in = v; rs1 = r1; rt1 = t1; dest1 = d1; wr1 = w1; mem1 = m1; br1 = b1;
    rs2 = r2; rt2 = t2; dest2 = d2; wr2 = w2; mem2 = m2; br2 = b2;
  endtask

  // one cycle: compare against the model before the edge, then advance the model
  task automatic cyc(input string tag);
    logic sp;
    logic [3:0] eo;
    int es, et;
    #2;
    sp = valid_in && ((wr1 && dest1 != 0 && (rs2 == dest1 || rt2 == dest1))
                   || (wr1 && wr2 && dest1 != 0 && dest1 == dest2)
                   || (mem1 && mem2) || br2);
    eo = 4'b0000;
    if (rst && !flush && valid_in)
      eo = ld_hazard ? 4'b0001 : (!m_half ? {2'b10, !sp, sp} : 4'b1100);
    chk({tag, "/out"}, outs(), eo);
`ifdef ISSUE_PERF_CNT_EN
    es = rst ? m_split : 0;
    et = rst ? m_stall : 0;
`else
    es = 0;
    et = 0;
`endif
    chk({tag, "/split_cnt"}, split_cnt, es);
    chk({tag, "/stall_cnt"}, stall_cnt, et);
    @(posedge clk);
    if (!rst) begin
      m_half = 1'b0; m_split = 0; m_stall = 0;
    end else begin
      if (valid_in && ld_hazard && !flush && m_stall < CMAX) m_stall++;
      if (flush) m_half = 1'b0;
      else if (valid_in && !ld_hazard) begin
        if (!m_half && sp) begin
          m_half = 1'b1;
          if (m_split < CMAX) m_split++;
        end else m_half = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int es, et;
    rst = 1'b0; ld_hazard = 1'b0; flush = 1'b0;
    set_pair(1, 1, 2, 3, 1, 0, 0, 4, 5, 6, 1, 0, 0);
    @(negedge clk);
    expect_out("reset", 4'b0000);
    cyc("reset");
    cyc("reset2");
    rst = 1'b1;
    set_pair(1, 0, 0, 5, 1, 0, 0, 3, 0, 7, 1, 0, 0);
    expect_out("t1_indep", 4'b1010);
    cyc("t1");
    set_pair(1, 0, 0, 5, 1, 0, 0, 1, 5, 7, 1, 0, 0);
    expect_out("t2_raw_c0", 4'b1001);
    cyc("t2a");
    expect_out("t2_raw_c1", 4'b1100);
    cyc("t2b");
    set_pair(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    expect_out("t3_zero_dest", 4'b1010);
    cyc("t3");
    rst = 1'b0;
    cyc("t4rst");
    rst = 1'b1;
    set_pair(1, 1, 2, 3, 0, 1, 0, 4, 5, 6, 0, 1, 0);
    expect_out("t4_mem_split", 4'b1001);
    cyc("t4a");
    ld_hazard = 1'b1;
    expect_out("t4_ld_half0", 4'b0001);
    cyc("t4b");
    expect_out("t4_ld_half1", 4'b0001);
    cyc("t4c");
    ld_hazard = 1'b0;
    expect_out("t4_resume", 4'b1100);
    cyc("t4d");
`ifdef ISSUE_PERF_CNT_EN
    es = 1; et = 2;
`else
    es = 0; et = 0;
`endif
    chk("t4_split_cnt", split_cnt, es);
    chk("t4_stall_cnt", stall_cnt, et);
    set_pair(1, 0, 0, 9, 1, 0, 0, 9, 0, 4, 0, 0, 0);
    expect_out("t5_split", 4'b1001);
    cyc("t5a");
    flush = 1'b1;
    expect_out("t5_flush", 4'b0000);
    cyc("t5b");
    flush = 1'b0;
    set_pair(1, 0, 0, 9, 1, 0, 0, 1, 2, 4, 1, 0, 0);
    expect_out("t5_after", 4'b1010);
    cyc("t5c");
    set_pair(1, 0, 0, 0, 0, 0, 0, 1, 2, 4, 1, 0, 1);
    expect_out("t6_br2_split", 4'b1001);
    cyc("t6a");
    rst = 1'b0;
    expect_out("t6_rst", 4'b0000);
    chk("t6_rst_split_cnt", split_cnt, 0);
    cyc("t6b");
    rst = 1'b1;
    set_pair(1, 0, 0, 9, 1, 0, 0, 1, 2, 4, 1, 0, 0);
    expect_out("t6_full", 4'b1010);
    chk("t6_split_cnt", split_cnt, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
    cyc("t6c");
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_pair($urandom_range(0, 4) != 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      ld_hazard = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cyc("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
